execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 id_ex_wb  input  2  {regwrite, memtoreg} from the ID/EX latch.
REQ-004 id_ex_mem  input  3  {branch, memread, memwrite}.
REQ-005 id_ex_execute  input  4  {regdst, aluop[1:0], alusrc}.
REQ-006 id_ex_npc  input  32  PC+4 of the instruction.
REQ-007 id_ex_readdat1 / id_ex_readdat2  input  32 each  rs / rt operands.
REQ-008 id_ex_sign_ext  input  32  sign-extended immediate; bits [5:0] are funct.
REQ-009 id_ex_instr_bits_20_16 / id_ex_instr_bits_15_11  input  5 each  rt / rd fields.
REQ-010 ex_stall  input  1  hold the EX/MEM latch.
REQ-011 ex_flush  input  1  load a bubble into the EX/MEM latch.
REQ-012 ex_mem_wb  output  2  latched id_ex_wb.
REQ-013 ex_mem_mem  output  3  latched id_ex_mem.
REQ-014 ex_mem_branch_target  output  32  latched npc + (sign_ext << 2).
REQ-015 ex_mem_zero  output  1  latched ALU-result-equals-zero flag.
REQ-016 ex_mem_alu_result  output  32  latched ALU result.
REQ-017 ex_mem_readdat2  output  32  latched rt operand (store data).
REQ-018 ex_mem_write_reg  output  5  latched destination register.

Function
REQ-019 Operand B SHALL be id_ex_sign_ext when alusrc=1, else id_ex_readdat2.
REQ-020 write_reg SHALL be bits_15_11 when regdst=1, else bits_20_16.
REQ-021 ALU control SHALL decode as follows: aluop 00 -> ADD; 01 -> SUB; 11 -> ADD; 10 -> by funct.
REQ-022 Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT; any other funct -> NOP, which produces result 0.
REQ-023 ADD/SUB SHALL be 32-bit modulo (wrap-around, no overflow flag or trap).
REQ-024 SLT SHALL be a signed compare producing 32'h1 or 32'h0.
REQ-025 zero SHALL be 1 exactly when the 32-bit ALU result equals 0.
REQ-026 Branch target SHALL be the 32-bit modulo sum npc + {sign_ext[29:0], 2'b00}.
REQ-027 All EX/MEM outputs SHALL update one clock after the inputs are presented (latency 1), with no combinational input-to-output path.
REQ-028 ex_flush=1 at a rising edge SHALL load zeros into all EX/MEM outputs.
REQ-029 ex_stall=1 with ex_flush=0 SHALL hold all EX/MEM outputs unchanged.
REQ-030 When ex_stall and ex_flush are both 1, flush SHALL win.

Reset
REQ-031 rst=0 SHALL immediately, independent of clk, force every EX/MEM output to 0.
REQ-032 An instruction in flight when reset asserts SHALL be discarded; the first capture occurs on the first rising edge after rst returns to 1.

Structure
REQ-033 A shared package SHALL hold:
  - the ALU-control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NOP 1111;
  - the aluop encodings;
  - the funct constants.
REQ-034 The ALU SHALL be one sub-module, alu, taking a 4-bit control and two 32-bit operands and producing a 32-bit result and zero; ALU-control decode, muxes and latch remain in execute_stage.

Verification
REQ-035 add: rs=0x11121951, rt=0x23938222, execute=1100, funct=100000 -> next edge alu_result=0x34A59B73, zero=0, write_reg=rd.
REQ-036 lw: rs=0x11121951, sign_ext=8, execute=0001, wb=11, mem=010 -> alu_result=0x11121959, write_reg=rt, wb=11, mem=010.
REQ-037 beq: npc=0x10, sign_ext=0xFFFFFFFF, execute=0010, rs=0x11121951, rt=0x23938222 -> branch_target=0x0000000C, zero=0; with rs=rt -> zero=1.
REQ-038 slt: rs=0x80000000, rt=0x00000001 -> alu_result=1; swapped operands -> 0; unknown funct 111111 -> alu_result=0, zero=1.
REQ-039 Stall/flush: stall for 2 cycles holds the prior values; flush with stall -> all outputs 0 on the next edge.
REQ-040 Reset mid-operation: drive rst=0 between clock edges -> outputs go to 0 before the next edge and stay 0 until the first edge after release.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// ---------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the EX stage of the 5-stage MIPS-style pipeline:
//   - ALU control codes driven from execute_stage into alu
//   - aluop encodings carried in id_ex_execute[2:1]
//   - R-type funct codes found in id_ex_sign_ext[5:0]
//   - ex_mem_t, the packed contents of the EX/MEM pipeline latch
// ---------------------------------------------------------------------------
package execute_stage_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // aluop encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD     = 2'b00;  // load/store address
  localparam logic [1:0] ALUOP_SUB     = 2'b01;  // beq compare
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;  // R-type, decode funct
  localparam logic [1:0] ALUOP_ADD_IMM = 2'b11;  // immediate add

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // EX/MEM latch contents
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] branch_target;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] readdat2;
    logic [4:0]  write_reg;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU.
// Ports:
//   ctrl   [3:0]  ALU control code (execute_stage_pkg::ALU_*)
//   a, b   [31:0] operands
//   result [31:0] operation result (0 for NOP / unknown codes)
//   zero          1 when result == 0
// ---------------------------------------------------------------------------
module alu
  import execute_stage_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = 32'h0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;  // modulo 2^32, no overflow detection
      ALU_SUB: result = a - b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      ALU_NOR: result = ~(a | b);
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// EX stage of the pipeline: ALU control decode, operand/destination muxes,
// branch-target adder, ALU instance and the EX/MEM pipeline latch.
// Ports:
//   clk, rst (async, active-low)
//   id_ex_*       ID/EX latch contents (control groups, npc, operands,
//                 sign-extended immediate, rt/rd fields)
//   ex_stall      hold the EX/MEM latch
//   ex_flush      load a bubble (all zeros); overrides ex_stall
//   ex_mem_*      registered EX/MEM latch outputs (latency 1)
// ---------------------------------------------------------------------------
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  id_ex_wb,
  input  logic [2:0]  id_ex_mem,
  input  logic [3:0]  id_ex_execute,
  input  logic [31:0] id_ex_npc,
  input  logic [31:0] id_ex_readdat1,
  input  logic [31:0] id_ex_readdat2,
  input  logic [31:0] id_ex_sign_ext,
  input  logic [4:0]  id_ex_instr_bits_20_16,
  input  logic [4:0]  id_ex_instr_bits_15_11,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic [1:0]  ex_mem_wb,
  output logic [2:0]  ex_mem_mem,
  output logic [31:0] ex_mem_branch_target,
  output logic        ex_mem_zero,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_readdat2,
  output logic [4:0]  ex_mem_write_reg
);

  // id_ex_execute = {regdst, aluop[1:0], alusrc}
  logic       regdst;
  logic [1:0] aluop;
  logic       alusrc;
  assign regdst = id_ex_execute[3];
  assign aluop  = id_ex_execute[2:1];
  assign alusrc = id_ex_execute[0];

  logic [5:0]  funct;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [4:0]  write_reg;
  logic [31:0] branch_target;

  assign funct = id_ex_sign_ext[5:0];

  // ALU control decode
  always_comb begin
    alu_ctrl = ALU_NOP;
    case (aluop)
      ALUOP_ADD, ALUOP_ADD_IMM: alu_ctrl = ALU_ADD;
      ALUOP_SUB:                alu_ctrl = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_NOR: alu_ctrl = ALU_NOR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_NOP;
        endcase
      end
    endcase
  end

  assign op_b          = alusrc ? id_ex_sign_ext : id_ex_readdat2;
  assign write_reg     = regdst ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
  // Word offset: shift left by two, upper two bits fall off (modulo add).
  assign branch_target = id_ex_npc + {id_ex_sign_ext[29:0], 2'b00};

  alu u_alu (
    .ctrl   (alu_ctrl),
    .a      (id_ex_readdat1),
    .b      (op_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // EX/MEM latch
  ex_mem_t ex_mem_d;
  ex_mem_t ex_mem_q;

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (ex_flush) begin
      ex_mem_d = '0;            // flush has priority over stall
    end else if (!ex_stall) begin
      ex_mem_d.wb            = id_ex_wb;
      ex_mem_d.mem           = id_ex_mem;
      ex_mem_d.branch_target = branch_target;
      ex_mem_d.zero          = alu_zero;
      ex_mem_d.alu_result    = alu_result;
      ex_mem_d.readdat2      = id_ex_readdat2;
      ex_mem_d.write_reg     = write_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex_mem_wb            = ex_mem_q.wb;
  assign ex_mem_mem           = ex_mem_q.mem;
  assign ex_mem_branch_target = ex_mem_q.branch_target;
  assign ex_mem_zero          = ex_mem_q.zero;
  assign ex_mem_alu_result    = ex_mem_q.alu_result;
  assign ex_mem_readdat2      = ex_mem_q.readdat2;
  assign ex_mem_write_reg     = ex_mem_q.write_reg;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Self-checking bench for execute_stage: directed vectors, stall/flush,
// asynchronous reset mid-operation and randomized traffic compared against a
// behavioural model of the EX/MEM latch.
// ---------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_mem;
  logic [3:0]  id_ex_execute;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_readdat1;
  logic [31:0] id_ex_readdat2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_instr_bits_20_16;
  logic [4:0]  id_ex_instr_bits_15_11;
  logic        ex_stall;
  logic        ex_flush;
  logic [1:0]  ex_mem_wb;
  logic [2:0]  ex_mem_mem;
  logic [31:0] ex_mem_branch_target;
  logic        ex_mem_zero;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_readdat2;
  logic [4:0]  ex_mem_write_reg;

  execute_stage dut (
    .clk                    (clk),
    .rst                    (rst),
    .id_ex_wb               (id_ex_wb),
    .id_ex_mem              (id_ex_mem),
    .id_ex_execute          (id_ex_execute),
    .id_ex_npc              (id_ex_npc),
    .id_ex_readdat1         (id_ex_readdat1),
    .id_ex_readdat2         (id_ex_readdat2),
    .id_ex_sign_ext         (id_ex_sign_ext),
    .id_ex_instr_bits_20_16 (id_ex_instr_bits_20_16),
    .id_ex_instr_bits_15_11 (id_ex_instr_bits_15_11),
    .ex_stall               (ex_stall),
    .ex_flush               (ex_flush),
    .ex_mem_wb              (ex_mem_wb),
    .ex_mem_mem             (ex_mem_mem),
    .ex_mem_branch_target   (ex_mem_branch_target),
    .ex_mem_zero            (ex_mem_zero),
    .ex_mem_alu_result      (ex_mem_alu_result),
    .ex_mem_readdat2        (ex_mem_readdat2),
    .ex_mem_write_reg       (ex_mem_write_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected EX/MEM contents
  logic [1:0]  m_wb;
  logic [2:0]  m_mem;
  logic [31:0] m_bt;
  logic        m_zero;
  logic [31:0] m_res;
  logic [31:0] m_rd2;
  logic [4:0]  m_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference ALU straight from the instruction-set rules.
  function automatic logic [31:0] ref_alu(input logic [1:0] aluop, input logic [5:0] funct,
                                          input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    if (aluop == 2'b00 || aluop == 2'b11) return a + b;
    if (aluop == 2'b01) return a - b;
    case (funct)
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd39:   return ~(a | b);
      6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_wb = 0; m_mem = 0; m_bt = 0; m_zero = 0; m_res = 0; m_rd2 = 0; m_wr = 0;
  endtask

  task automatic model_capture();
    logic [31:0] b;
    if (ex_flush) begin
      model_clear();
    end else if (!ex_stall) begin
      b      = id_ex_execute[0] ? id_ex_sign_ext : id_ex_readdat2;
      m_res  = ref_alu(id_ex_execute[2:1], id_ex_sign_ext[5:0], id_ex_readdat1, b);
      m_zero = (m_res == 0);
      m_bt   = id_ex_npc + id_ex_sign_ext * 4;
      m_wb   = id_ex_wb;
      m_mem  = id_ex_mem;
      m_rd2  = id_ex_readdat2;
      m_wr   = id_ex_execute[3] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wb"},  32'(ex_mem_wb),   32'(m_wb));
    check({tag, ".mem"}, 32'(ex_mem_mem),  32'(m_mem));
    check({tag, ".bt"},  ex_mem_branch_target, m_bt);
    check({tag, ".zero"}, 32'(ex_mem_zero), 32'(m_zero));
    check({tag, ".res"}, ex_mem_alu_result, m_res);
    check({tag, ".rd2"}, ex_mem_readdat2,  m_rd2);
    check({tag, ".wr"},  32'(ex_mem_write_reg), 32'(m_wr));
  endtask

  // One clock: model captures what the DUT sees at the edge, compare #1 later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_capture();
    #1;
    check_all(tag);
    $display("%s: stall=%0b flush=%0b res=%h zero=%0b wr=%0d bt=%h", tag, ex_stall, ex_flush,
             ex_mem_alu_result, ex_mem_zero, ex_mem_write_reg, ex_mem_branch_target);
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] exe,
                       input logic [31:0] npc, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] se, input logic [4:0] f_rt, input logic [4:0] f_rd);
    id_ex_wb = wb; id_ex_mem = mem; id_ex_execute = exe; id_ex_npc = npc;
    id_ex_readdat1 = rs; id_ex_readdat2 = rt; id_ex_sign_ext = se;
    id_ex_instr_bits_20_16 = f_rt; id_ex_instr_bits_15_11 = f_rd;
  endtask

  initial begin
    logic [5:0] funct_tab [8];
    funct_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                  6'b100111, 6'b101010, 6'b111111, 6'b000000};
    rst = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // add
    drive(2'b10, 3'b000, 4'b1100, 32'h4, 32'h11121951, 32'h23938222, 32'h00001820, 5'd3, 5'd7);
    tick("add");
    check("add.lit", ex_mem_alu_result, 32'h34A59B73);
    // lw
    drive(2'b11, 3'b010, 4'b0001, 32'h8, 32'h11121951, 32'h0, 32'h8, 5'd9, 5'd2);
    tick("lw");
    check("lw.lit", ex_mem_alu_result, 32'h11121959);
    // beq not taken / taken
    drive(2'b00, 3'b100, 4'b0010, 32'h10, 32'h11121951, 32'h23938222, 32'hFFFFFFFF, 5'd1, 5'd2);
    tick("beq_ne");
    check("beq.bt.lit", ex_mem_branch_target, 32'h0000000C);
    drive(2'b00, 3'b100, 4'b0010, 32'h10, 32'h11121951, 32'h11121951, 32'hFFFFFFFF, 5'd1, 5'd2);
    tick("beq_eq");
    check("beq.zero.lit", 32'(ex_mem_zero), 32'h1);
    // slt signed, swapped, unknown funct
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h80000000, 32'h00000001, 32'h0000002A, 5'd4, 5'd5);
    tick("slt_lt");
    check("slt.lit", ex_mem_alu_result, 32'h1);
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h00000001, 32'h80000000, 32'h0000002A, 5'd4, 5'd5);
    tick("slt_ge");
    drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h0000003F, 5'd4, 5'd5);
    tick("nop_funct");
    // stall two cycles holding values, then flush with stall
    drive(2'b10, 3'b000, 4'b1100, 32'h20, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000025, 5'd6, 5'd8);
    tick("or");
    drive(2'b01, 3'b001, 4'b0001, 32'h99, 32'h1, 32'h2, 32'h3, 5'd10, 5'd11);
    ex_stall = 1'b1;
    tick("stall1");
    tick("stall2");
    check("stall.hold.lit", ex_mem_alu_result, 32'hFFF0FFF0);
    ex_flush = 1'b1;
    tick("flush_stall");
    ex_stall = 1'b0; ex_flush = 1'b0;

    // reset between edges
    drive(2'b11, 3'b010, 4'b0001, 32'h40, 32'h100, 32'h5, 32'h4, 5'd12, 5'd13);
    tick("pre_rst");
    #2 rst = 1'b0;
    model_clear();
    #1 check_all("rst_async");
    @(posedge clk); #1 check_all("rst_hold");
    @(negedge clk); rst = 1'b1;
    #1 check_all("rst_released");
    tick("post_rst");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rs, rt, se;
      rs = $urandom();
      rt = ($urandom_range(0, 7) == 0) ? rs : $urandom();
      se = $urandom();
      if ($urandom_range(0, 1) == 1) se[5:0] = funct_tab[$urandom_range(0, 7)];
      drive(2'($urandom()), 3'($urandom()), 4'($urandom()), $urandom(), rs, rt, se,
            5'($urandom()), 5'($urandom()));
      ex_stall = ($urandom_range(0, 7) == 0);
      ex_flush = ($urandom_range(0, 11) == 0);
      tick($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
